shift_add_multiplier_4: RTL and testbench



---
 rtl/shift_add_multiplier_4_pkg.sv | 14 +
 rtl/shift_add_multiplier_4_if.sv | 24 ++
 rtl/ripple_carry_adder_4.sv | 21 ++
 rtl/shift_add_multiplier_4.sv | 97 +++++++++
 tb/tb_shift_add_multiplier_4.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_multiplier_4_pkg.sv
// Shared types and constants for the 4x4 shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    localparam int MULT_WIDTH  = 4;
    localparam int MULT_STEPS  = 4;
    localparam int COUNT_WIDTH = 2;

endpackage : mult_pkg

// File: rtl/shift_add_multiplier_4_if.sv
// Start/done handshake and operand/result bus of the multiplier.
interface shift_add_multiplier_4_if;
    import mult_pkg::*;

    logic                      i_start;
    logic [MULT_WIDTH-1:0]     i_a;
    logic [MULT_WIDTH-1:0]     i_b;
    logic                      o_busy;
    logic                      o_done;
    logic [2*MULT_WIDTH-1:0]   o_product;

    // Issuing side: drives operands and start, observes status and result.
    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_product
    );

    // Multiplier side.
    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_product
    );

endinterface : shift_add_multiplier_4_if

// File: rtl/ripple_carry_adder_4.sv
// 4-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry_in,
    output logic [3:0] o_sum,
    output logic       o_carry_out
);

    logic [4:0] carry;

    assign carry[0] = i_carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ carry[i];
        assign carry[i+1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry_out = carry[4];

endmodule : ripple_carry_adder_4

// File: rtl/shift_add_multiplier_4.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one add-and-shift step
// per clock for four clocks, registered 8-bit product with start/done pulse.
module shift_add_multiplier_4
    import mult_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    shift_add_multiplier_4_if.slave   bus
);

    mult_state_t              state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    // The working register is architecturally P[8:0], but P[8] is zero after
    // every step (the product never exceeds 225), so only P[7:0] is stored.
    logic [2*MULT_WIDTH-1:0]  p_q, p_d;
    logic [MULT_WIDTH-1:0]    m_q, m_d;
    logic [2*MULT_WIDTH-1:0]  product_q, product_d;
    logic                     done_q, done_d;

    logic [MULT_WIDTH-1:0]    addend;
    logic [MULT_WIDTH-1:0]    sum;
    logic                     carry;

    // Add the multiplicand into the upper half only when the multiplier LSB is set.
    assign addend = p_q[0] ? m_q : '0;

    ripple_carry_adder_4 u_adder (
        .i_a         (p_q[7:4]),
        .i_b         (addend),
        .i_carry_in  (1'b0),
        .o_sum       (sum),
        .o_carry_out (carry)
    );

    // Next-state, accept and add-and-shift step logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        count_d   = count_q;
        p_d       = p_q;
        m_d       = m_q;
        product_d = product_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    m_d     = bus.i_a;
                    p_d     = {{MULT_WIDTH{1'b0}}, bus.i_b};
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Carry-out lands in P[7] as the whole register shifts right.
                p_d     = {carry, sum, p_q[3:1]};
                count_d = count_q + 1'b1;
                if (count_q == COUNT_WIDTH'(MULT_STEPS - 1)) begin
                    product_d = {carry, sum, p_q[3:1]};
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        // NOTE: all datapath registers are reset too, so a partial result is discarded.
        if (!i_rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            p_q       <= '0;
            m_q       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            count_q   <= count_d;
            p_q       <= p_d;
            m_q       <= m_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy    = (state_q == RUN);
    assign bus.o_done    = done_q;
    assign bus.o_product = product_q;

endmodule : shift_add_multiplier_4

// File: tb/tb_shift_add_multiplier_4.sv
// Directed self-checking bench for shift_add_multiplier_4.
module tb_shift_add_multiplier_4;

    logic i_clk;
    logic i_rst_n;

    int vectors;
    int miscompares;

    shift_add_multiplier_4_if u_if ();

    shift_add_multiplier_4 u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (u_if.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic busy, input logic done, input logic [7:0] product);
        check({tag, " busy"},    32'(u_if.o_busy),    32'(busy));
        check({tag, " done"},    32'(u_if.o_done),    32'(done));
        check({tag, " product"}, 32'(u_if.o_product), 32'(product));
    endtask

    // Accept on E0, run E1..E4, product on E4, done cleared after E5.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] prev, input logic [7:0] expected);
        u_if.i_start = 1'b1;
        u_if.i_a     = a;
        u_if.i_b     = b;
        tick();
        u_if.i_start = 1'b0;
        check_outputs({tag, " E0"}, 1'b1, 1'b0, prev);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_outputs({tag, " run"}, 1'b1, 1'b0, prev);
        end
        tick();
        check_outputs({tag, " E4"}, 1'b0, 1'b1, expected);
        tick();
        check_outputs({tag, " E5"}, 1'b0, 1'b0, expected);
    endtask

    initial begin
        int done_count;
        vectors     = 0;
        miscompares = 0;
        i_rst_n      = 1'b0;
        u_if.i_start = 1'b0;
        u_if.i_a     = 4'h0;
        u_if.i_b     = 4'h0;

        // Reset then idle.
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0, 8'h00);
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_outputs("idle", 1'b0, 1'b0, 8'h00);
        end

        // Basic and corner products.
        run_op("a_x_3", 4'hA, 4'h3, 8'h00, 8'h1E);
        run_op("f_x_f", 4'hF, 4'hF, 8'h1E, 8'hE1);
        run_op("0_x_7", 4'h0, 4'h7, 8'hE1, 8'h00);
        run_op("7_x_0", 4'h7, 4'h0, 8'h00, 8'h00);

        // Start while busy: 5x6, then F x F requested on E2 and E3.
        done_count   = 0;
        u_if.i_start = 1'b1;
        u_if.i_a     = 4'h5;
        u_if.i_b     = 4'h6;
        tick();                              // E0
        u_if.i_start = 1'b0;
        tick();                              // E1
        u_if.i_start = 1'b1;
        u_if.i_a     = 4'hF;
        u_if.i_b     = 4'hF;
        tick();                              // E2
        check_outputs("busy_start E2", 1'b1, 1'b0, 8'h00);
        tick();                              // E3
        u_if.i_start = 1'b0;
        check_outputs("busy_start E3", 1'b1, 1'b0, 8'h00);
        tick();                              // E4
        check_outputs("busy_start E4", 1'b0, 1'b1, 8'h1E);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (u_if.o_done) done_count++;
        end
        check("busy_start extra done", 32'(done_count), 32'd0);
        check_outputs("busy_start after", 1'b0, 1'b0, 8'h1E);

        // Back-to-back: 3x4 then 9x9 accepted in the DONE cycle.
        u_if.i_start = 1'b1;
        u_if.i_a     = 4'h3;
        u_if.i_b     = 4'h4;
        tick();                              // E0
        check_outputs("b2b E0", 1'b1, 1'b0, 8'h1E);
        tick();
        tick();
        tick();
        check_outputs("b2b E3", 1'b1, 1'b0, 8'h1E);
        tick();                              // E4
        check_outputs("b2b first", 1'b0, 1'b1, 8'h0C);
        u_if.i_a = 4'h9;
        u_if.i_b = 4'h9;
        tick();                              // E5 accepts 9x9
        u_if.i_start = 1'b0;
        check_outputs("b2b accept", 1'b1, 1'b0, 8'h0C);
        tick();
        tick();
        tick();
        check_outputs("b2b E8", 1'b1, 1'b0, 8'h0C);
        tick();                              // E9
        check_outputs("b2b second", 1'b0, 1'b1, 8'h51);
        tick();
        check_outputs("b2b idle", 1'b0, 1'b0, 8'h51);

        // Reset mid-operation: C x D, reset on E2.
        u_if.i_start = 1'b1;
        u_if.i_a     = 4'hC;
        u_if.i_b     = 4'hD;
        tick();                              // E0
        u_if.i_start = 1'b0;
        tick();                              // E1
        i_rst_n = 1'b0;
        tick();                              // E2
        i_rst_n = 1'b1;
        check_outputs("midreset", 1'b0, 1'b0, 8'h00);
        done_count = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (u_if.o_done) done_count++;
        end
        check("midreset done", 32'(done_count), 32'd0);
        check_outputs("midreset idle", 1'b0, 1'b0, 8'h00);
        run_op("2_x_3", 4'h2, 4'h3, 8'h00, 8'h06);

        // Exhaustive sweep, back-to-back with operands changed in each DONE cycle.
        u_if.i_start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                u_if.i_a = 4'(a);
                u_if.i_b = 4'(b);
                tick();                      // accept
                check("sweep busy", 32'(u_if.o_busy), 32'd1);
                tick();
                tick();
                tick();
                check("sweep early done", 32'(u_if.o_done), 32'd0);
                tick();                      // fourth step
                check("sweep done", 32'(u_if.o_done), 32'd1);
                check("sweep product", 32'(u_if.o_product), 32'(a * b));
            end
        end
        u_if.i_start = 1'b0;
        tick();
        check_outputs("sweep end", 1'b0, 1'b0, 8'hE1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_add_multiplier_4
